// File: rtl/spr_dma_if.sv
// spr_dma_if: CPU/memory bus seen by the sprite DMA engine.
// slave is the DMA side, master is the CPU/memory side.
interface spr_dma_if;
  logic [15:0] cpumc_a_in;
  logic [7:0]  cpumc_din_in;
  logic [7:0]  cpumc_dout_in;
  logic        cpu_r_nw_in;
  logic        active_out;
  logic [15:0] cpumc_a_out;
  logic [7:0]  cpumc_d_out;
  logic        cpumc_r_nw_out;

  modport slave (
    input  cpumc_a_in,
    input  cpumc_din_in,
    input  cpumc_dout_in,
    input  cpu_r_nw_in,
    output active_out,
    output cpumc_a_out,
    output cpumc_d_out,
    output cpumc_r_nw_out
  );

  modport master (
    output cpumc_a_in,
    output cpumc_din_in,
    output cpumc_dout_in,
    output cpu_r_nw_in,
    input  active_out,
    input  cpumc_a_out,
    input  cpumc_d_out,
    input  cpumc_r_nw_out
  );
endinterface

// File: rtl/spr_dma.sv
// spr_dma: copies one 256-byte CPU page into the PPU OAM data port.
// Define SPR_DMA_ODD_ALIGN_EN to add an extra align cycle on odd-cycle triggers.
module spr_dma #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic      clk_in,
  input  logic      rst_in,
  spr_dma_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_READ,
    S_WRITE
`ifdef SPR_DMA_ODD_ALIGN_EN
    , S_ALIGN2
`endif
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  page_q;
  logic [7:0]  page_d;
  logic [7:0]  idx_q;
  logic [7:0]  idx_d;

  logic        trig;
  logic        active;
  logic [15:0] a_out;
  logic [7:0]  d_out;
  logic        r_nw_out;

  assign trig = !bus.cpu_r_nw_in &&
                (bus.cpumc_a_in == TRIGGER_ADDR);

`ifdef SPR_DMA_ODD_ALIGN_EN
  logic par_q;

  // Free-running cycle parity; the first cycle after reset is even.
  always_ff @(posedge clk_in) begin
    if (rst_in) par_q <= 1'b0;
    else        par_q <= ~par_q;
  end
`endif

  // State, page and byte index registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
    end
  end

  // Next state and bus outputs; reset forces idle bus values at once.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    active   = 1'b0;
    a_out    = 16'h0000;
    d_out    = 8'h00;
    r_nw_out = 1'b1;
    if (!rst_in) begin
      unique case (state_q)
        S_IDLE: begin
          if (trig) begin
            page_d  = bus.cpumc_dout_in;
            idx_d   = 8'h00;
            state_d = S_ALIGN;
          end
        end
        S_ALIGN: begin
          active = 1'b1;
`ifdef SPR_DMA_ODD_ALIGN_EN
          // Parity has flipped since the trigger cycle.
          state_d = par_q ? S_READ : S_ALIGN2;
`else
          state_d = S_READ;
`endif
        end
`ifdef SPR_DMA_ODD_ALIGN_EN
        S_ALIGN2: begin
          active  = 1'b1;
          state_d = S_READ;
        end
`endif
        S_READ: begin
          active  = 1'b1;
          a_out   = {page_q, idx_q};
          state_d = S_WRITE;
        end
        S_WRITE: begin
          active   = 1'b1;
          a_out    = OAM_DATA_ADDR;
          d_out    = bus.cpumc_din_in;
          r_nw_out = 1'b0;
          if (idx_q == 8'hFF) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 8'h01;
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.active_out     = active;
  assign bus.cpumc_a_out    = a_out;
  assign bus.cpumc_d_out    = d_out;
  assign bus.cpumc_r_nw_out = r_nw_out;

endmodule

// File: tb/tb_spr_dma.sv
// tb_spr_dma: randomized scoreboard bench for the sprite DMA engine.
// Stimulus pushes expected OAM writes and run lengths; a monitor pops them.
module tb_spr_dma;
  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] OAM  = 16'h2004;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  spr_dma_if bus();

  spr_dma #(
    .TRIGGER_ADDR (TRIG),
    .OAM_DATA_ADDR(OAM)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #10 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  wq[$];
  logic [15:0] rq[$];
  int          lq[$];

  int          run = 0;
  logic [15:0] prev_a = 16'h0;
  logic        prev_rnw = 1'b1;
  logic [7:0]  ed;
  logic [15:0] er;

  // cycle parity as the block should see it
  always @(posedge clk_in) cyc <= rst_in ? 0 : cyc + 1;

  // memory: data for an address arrives the following cycle
  always @(posedge clk_in)
    bus.cpumc_din_in <= bus.cpumc_a_out[7:0] ^ 8'h5A;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: OAM writes, read address before each write, run lengths
  always @(negedge clk_in) begin
    if (bus.active_out) begin
      run++;
      if (!bus.cpumc_r_nw_out) begin
        chk("write_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          ed = wq.pop_front();
          er = rq.pop_front();
          chk("oam_write", 32'({bus.cpumc_a_out, bus.cpumc_d_out}),
              32'({OAM, ed}));
          chk("read_addr", 32'({prev_rnw, prev_a}), 32'({1'b1, er}));
        end
      end
    end else if (run > 0) begin
      chk("run_expected", 32'(lq.size() != 0), 32'd1);
      if (lq.size() != 0) chk("active_len", run, lq.pop_front());
      chk("idle_outs",
          32'({bus.cpumc_a_out, bus.cpumc_d_out, bus.cpumc_r_nw_out}),
          32'({16'h0, 8'h0, 1'b1}));
      run = 0;
    end
    prev_a   = bus.cpumc_a_out;
    prev_rnw = bus.cpumc_r_nw_out;
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_in;
    bus.cpumc_a_in    = 16'h0;
    bus.cpu_r_nw_in   = 1'b1;
    bus.cpumc_dout_in = 8'h0;
  endtask

  task automatic chk_rst_outs(input string nm);
    chk(nm, 32'({bus.active_out, bus.cpumc_a_out,
                 bus.cpumc_d_out, bus.cpumc_r_nw_out}),
        32'({1'b0, 16'h0, 8'h0, 1'b1}));
  endtask

  // one transfer; stray_at/rst_at are active-cycle numbers (0 = none)
  task automatic xfer(input logic [7:0] pg, input int stray_at,
                      input int rst_at);
    int al;
    int k;
    int n;
    al = 1;
`ifdef SPR_DMA_ODD_ALIGN_EN
    if (cyc[0]) al = 2;
`endif
    n = 256;
    if (rst_at > 0) begin
      n = 0;
      while (al + 2 + 2 * n < rst_at) n++;
    end
    for (int i = 0; i < n; i++) begin
      wq.push_back(8'(i) ^ 8'h5A);
      rq.push_back({pg, 8'(i)});
    end
    lq.push_back(rst_at > 0 ? rst_at - 1 : 512 + al);
    bus.cpumc_a_in    = TRIG;
    bus.cpu_r_nw_in   = 1'b0;
    bus.cpumc_dout_in = pg;
    tick;
    idle_in;
    k = 1;
    while (bus.active_out && k < 700) begin
      if (k == stray_at) begin
        bus.cpumc_a_in    = TRIG;
        bus.cpu_r_nw_in   = 1'b0;
        bus.cpumc_dout_in = 8'h07;
      end
      if (k == rst_at) begin
        rst_in = 1'b1;
        #1;
        chk_rst_outs("rst_during");
      end
      tick;
      idle_in;
      if (k == rst_at) begin
        rst_in = 1'b0;
        #1;
        chk_rst_outs("rst_after");
      end
      k++;
    end
    chk("xfer_bounded", 32'(k < 700), 32'd1);
  endtask

  task automatic noise(input int n);
    for (int i = 0; i < n; i++) begin
      bus.cpumc_a_in    = 16'($urandom);
      bus.cpu_r_nw_in   = 1'($urandom);
      bus.cpumc_dout_in = 8'($urandom);
      if (bus.cpumc_a_in == TRIG) bus.cpu_r_nw_in = 1'b1;
      tick;
    end
    idle_in;
    chk("noise_idle", 32'(bus.active_out), 32'd0);
  endtask

  task automatic wait_par(input bit p);
    if (cyc[0] != p) tick;
  endtask

  initial begin
    idle_in;
    rst_in = 1'b1;
    repeat (3) tick;
    chk_rst_outs("reset_held");
    rst_in = 1'b0;
    tick;
    chk_rst_outs("reset_idle");

    bus.cpumc_a_in    = TRIG;
    bus.cpu_r_nw_in   = 1'b1;
    bus.cpumc_dout_in = 8'h02;
    tick;
    bus.cpumc_a_in    = 16'h4015;
    bus.cpu_r_nw_in   = 1'b0;
    bus.cpumc_dout_in = 8'h03;
    tick;
    idle_in;
    chk("read_4014_no_start", 32'(bus.active_out), 32'd0);
    tick;
    chk("write_4015_no_start", 32'(bus.active_out), 32'd0);

    xfer(8'h02, 0, 0);
    repeat (2) tick;
    xfer(8'hFF, 0, 0);
    tick;
    xfer(8'h02, 100, 0);
    repeat (3) tick;
    xfer(8'($urandom_range(1, 255)), 0, 201);
    noise(6);
    repeat (4) tick;
    chk("post_rst_idle", 32'(bus.active_out), 32'd0);

    wait_par(1'b0);
    xfer(8'($urandom), 0, 0);
    tick;
    wait_par(1'b1);
    xfer(8'($urandom), 0, 0);

    for (int t = 0; t < 6; t++) begin
      noise($urandom_range(0, 6));
      xfer(8'($urandom),
           ($urandom_range(0, 1) != 0) ? $urandom_range(2, 510) : 0,
           0);
    end

    repeat (5) tick;
    chk("writes_drained", wq.size(), 0);
    chk("runs_drained", lq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
